uart_tx_frame: RTL and testbench

- Serial transmit end of the UART link; the counterpart of the RX datapath (sampler, deserializer, parity/stop checks).
- Accepts a parallel byte with a valid strobe and emits one frame: start bit, data LSB-first, optional parity bit, one stop bit.
- Runs on the TX bit clock, so one clock equals one bit period.
- Sits between the system-side FIFO/controller and the TX pad.

---
 rtl/uart_tx_frame.sv | 108 ++++++++++
 tb/tb_uart_tx_frame.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one clock per bit, emits start, LSB-first data,
// optional parity and one stop bit; back-to-back frames accepted in STOP.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_TX,
  input  logic                  RST_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_TX,
  input  logic                  DATA_VALID_TX,
  input  logic                  PAR_EN_TX,
  input  logic                  PAR_TYP_TX,
  output logic                  TX_OUT_TX,
  output logic                  BUSY_TX
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  tx_r;
  logic                  busy_r;

  // Parity bit that makes the data plus parity even (typ=0) or odd (typ=1).
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // Frame sequencer; outputs are registered alongside the state.
  always_ff @(posedge CLK_TX or negedge RST_TX) begin
    if (!RST_TX) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, STOP: begin
          if (DATA_VALID_TX) begin
            state_r   <= START;
            shift_r   <= P_DATA_TX;
            par_en_r  <= PAR_EN_TX;
            par_bit_r <= parity_of(P_DATA_TX, PAR_TYP_TX);
            cnt_r     <= {CNT_W{1'b0}};
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          state_r <= DATA;
          cnt_r   <= {CNT_W{1'b0}};
          tx_r    <= shift_r[0];
          shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
          busy_r  <= 1'b1;
        end
        DATA: begin
          busy_r <= 1'b1;
          // Counter tracks the bit currently on the line; it stops at LAST_BIT.
          if (cnt_r == LAST_BIT) begin
            if (par_en_r) begin
              state_r <= PARITY;
              tx_r    <= par_bit_r;
            end else begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            tx_r    <= shift_r[0];
            shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
          end
        end
        PARITY: begin
          state_r <= STOP;
          tx_r    <= 1'b1;
          busy_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT_TX = tx_r;
  assign BUSY_TX   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames compared bit by bit
// against an expected-frame list built from the framing rules.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int tests;
  int failed;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK_TX        (clk),
    .RST_TX        (rst_n),
    .P_DATA_TX     (p_data),
    .DATA_VALID_TX (data_valid),
    .PAR_EN_TX     (par_en),
    .PAR_TYP_TX    (par_typ),
    .TX_OUT_TX     (tx_out),
    .BUSY_TX       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx_out, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Play one frame and check every line cycle. preloaded: request already
  // taken on the previous STOP edge. chain: request the next word in STOP.
  task automatic play(input string name, input logic [7:0] d, input logic pen,
                      input logic ptyp, input bit preloaded, input bit noise,
                      input bit chain, input logic [7:0] nd, input logic npen,
                      input logic nptyp);
    logic exp_bits[$];
    int   ones;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_bits.push_back(d[k]);
      ones += int'(d[k]);
    end
    if (pen) exp_bits.push_back(ptyp ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    exp_bits.push_back(1'b1);

    if (!preloaded) begin
      p_data = d; par_en = pen; par_typ = ptyp; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("%s_bit%0d", name, i), tx_out, exp_bits[i]);
      check($sformatf("%s_busy%0d", name, i), busy, 1'b1);
      if (noise) begin
        p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
        data_valid = 1'($urandom);
      end
      if (i == exp_bits.size() - 1) begin
        data_valid = chain;
        if (chain) begin
          p_data = nd; par_en = npen; par_typ = nptyp;
        end
      end
      step();
      data_valid = 1'b0;
    end
    if (!chain) check_idle({name, "_after"});
  endtask

  initial begin
    logic [7:0] d, nd;
    logic       pen, ptyp, npen, nptyp;
    bit         pre, chain, noise;
    tests = 0; failed = 0;
    rst_n = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;

    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check_idle($sformatf("idle%0d", c));
    end

    play("a5_np", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    play("a5_ev", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    play("a5_od", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    play("07_ev", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    play("07_od", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    play("b2b_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    play("b2b_ff", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 8'h81 frame with a 8'h3C request and config toggling mid-data.
    p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("ign_start", tx_out, 1'b0);
    step();
    check("ign_d0", tx_out, 1'b1);
    step();
    p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    step();
    data_valid = 1'b0; p_data = 8'hFF; par_en = 1'b0;
    for (int k = 2; k < 8; k++) begin
      check($sformatf("ign_d%0d", k), tx_out, (k == 7) ? 1'b1 : 1'b0);
      check($sformatf("ign_busy%0d", k), busy, 1'b1);
      step();
    end
    check("ign_stop", tx_out, 1'b1);
    check("ign_stop_busy", busy, 1'b1);
    step();
    check_idle("ign_after");

    // Abort during data bit 3 of 8'h00.
    p_data = 8'h00; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    repeat (4) step();
    check("rst_d3", tx_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    step();
    check_idle("rst_held");
    rst_n = 1'b1;
    step();
    check_idle("rst_rel");
    play("rst_new", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    pre = 1'b0;
    d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
    for (int n = 0; n < 24; n++) begin
      chain = (n < 23) && ($urandom_range(0, 1) == 1);
      noise = ($urandom_range(0, 1) == 1);
      nd = 8'($urandom); npen = 1'($urandom); nptyp = 1'($urandom);
      play($sformatf("rnd%0d", n), d, pen, ptyp, pre, noise, chain, nd, npen, nptyp);
      if (!chain) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          step();
          check_idle($sformatf("rnd%0d_gap%0d", n, g));
        end
        d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
      end else begin
        d = nd; pen = npen; ptyp = nptyp;
      end
      pre = chain;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
